// File: rtl/aemb_mem_arb.sv
// Two-master (instruction/data) arbiter onto one single-port synchronous RAM.
// Data wins by default; a waiting instruction fetch is forced through after STARVE data grants.
module aemb_mem_arb #(
    parameter int unsigned AW     = 16,
    parameter int unsigned STARVE = 4
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_i,
    input  logic [AW-1:0] iwb_adr_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic          dwb_stb_i,
    input  logic          dwb_we_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          mem_en_o,
    output logic [3:0]    mem_we_o,
    output logic [AW-3:0] mem_adr_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i,
    output logic          err_o
);

    localparam int unsigned CW = $clog2(STARVE + 2);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE);

    typedef enum logic [1:0] {StIdle, StAccI, StAccD, StAck} state_e;

    state_e          state_q;
    logic            gnt_data_q;
    logic            mem_en_q;
    logic [3:0]      mem_we_q;
    logic [AW-3:0]   mem_adr_q;
    logic [31:0]     mem_dat_q;
    logic            iack_q;
    logic            dack_q;
    logic            err_q;
    logic [CW-1:0]   starve_q;

    logic            grant_i;
    logic            grant_d;
    logic            sel_ok;
    logic [CW-1:0]   starve_inc;
    logic            adr_lsb_unused;

    assign adr_lsb_unused = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

    always_comb begin
        unique case (dwb_sel_i)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_ok = 1'b1;
            default:                                  sel_ok = 1'b0;
        endcase
    end

    // Instruction only beats a pending data request once it has sat through STARVE data grants.
    always_comb begin
        grant_i    = iwb_stb_i && (!dwb_stb_i || (starve_q >= StarveMax));
        grant_d    = dwb_stb_i && !grant_i;
        starve_inc = (starve_q < StarveMax) ? starve_q + CW'(1) : starve_q;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q    <= StIdle;
            gnt_data_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 4'h0;
            mem_adr_q  <= '0;
            mem_dat_q  <= '0;
            iack_q     <= 1'b0;
            dack_q     <= 1'b0;
            err_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_i) begin
                        state_q    <= StAccI;
                        gnt_data_q <= 1'b0;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 4'h0;
                        mem_adr_q  <= iwb_adr_i[AW-1:2];
                        mem_dat_q  <= '0;
                        starve_q   <= '0;
                    end else if (grant_d) begin
                        state_q    <= StAccD;
                        gnt_data_q <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= (dwb_we_i && sel_ok) ? dwb_sel_i : 4'h0;
                        mem_adr_q  <= dwb_adr_i[AW-1:2];
                        mem_dat_q  <= dwb_dat_i;
                        starve_q   <= iwb_stb_i ? starve_inc : '0;
                        if (dwb_we_i && !sel_ok) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                StAccI, StAccD: begin
                    state_q  <= StAck;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 4'h0;
                    iack_q   <= !gnt_data_q;
                    dack_q   <= gnt_data_q;
                    if (!iwb_stb_i) begin
                        starve_q <= '0;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    iack_q  <= 1'b0;
                    dack_q  <= 1'b0;
                    if (!iwb_stb_i) begin
                        starve_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_en_o  = mem_en_q;
    assign mem_we_o  = mem_we_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_dat_o = mem_dat_q;
    assign iwb_ack_o = iack_q;
    assign dwb_ack_o = dack_q;
    assign err_o     = err_q;

    // RAM output is held while mem_en_o is low, so it can be passed straight through in ACK.
    assign iwb_dat_o = iack_q ? mem_dat_i : 32'h0;
    assign dwb_dat_o = dack_q ? mem_dat_i : 32'h0;

endmodule
